// File: rtl/ddfs_iq.sv
// ddfs_iq: quadrature DDFS with quarter-wave LUT, phase offset and wrap-synchronous frequency hopping
// The quarter-wave table holds the M=10 / LUT_AW=6 amplitudes.
module ddfs_iq #(
    parameter int N         = 16,
    parameter int M         = 10,
    parameter int LUT_AW    = 6,
    parameter int BIT_COUNT = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [N-1:0] fw_in,
    input  logic         fw_load,
    input  logic         hop_sync,
    input  logic [N-1:0] phase_off,
    output logic [M-1:0] sine,
    output logic [M-1:0] cosine,
    output logic         out_valid,
    output logic         wrap,
    output logic         led
);
    localparam int PW = LUT_AW + 2;
    localparam int MW = M - 1;
    // Q[k] = round(511 * sin(pi*(2k+1)/256)); half-step offset means no zero code
    localparam int QTAB [64] = '{
          6,  19,  31,  44,  56,  69,  81,  94, 106, 118, 130, 142, 154, 166, 178, 190,
        201, 213, 224, 235, 246, 257, 268, 279, 289, 299, 309, 319, 329, 338, 348, 357,
        366, 374, 383, 391, 399, 407, 414, 421, 428, 435, 441, 448, 454, 459, 465, 470,
        474, 479, 483, 487, 491, 494, 497, 500, 502, 505, 506, 508, 509, 510, 511, 511
    };

    logic [N-1:0]         acc;
    logic [N-1:0]         fw_active;
    logic [N-1:0]         fw_pending;
    logic                 pend_flag;
    logic [N:0]           nxt;
    logic                 carry;
    logic [PW-1:0]        ph;
    logic [1:0]           q;
    logic [LUT_AW-1:0]    idx;
    logic [MW-1:0]        mag_s;
    logic [MW-1:0]        mag_c;
    logic                 neg_s;
    logic                 neg_c;
    logic [1:0]           vpipe;
    logic [BIT_COUNT-1:0] wcnt;

    assign nxt   = {1'b0, acc} + {1'b0, fw_active};
    assign carry = nxt[N];
    assign q     = ph[PW-1 -: 2];
    assign idx   = ph[LUT_AW-1:0];

    // Stage 0: phase accumulator and carry-out pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc  <= '0;
            wrap <= 1'b0;
        end else begin
            if (en) acc <= nxt[N-1:0];
            wrap <= en & carry;
        end
    end

    // Frequency word: immediate load wins; otherwise a pending word is applied on the carrying step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fw_active  <= '0;
            fw_pending <= '0;
            pend_flag  <= 1'b0;
        end else if (fw_load && !hop_sync) begin
            fw_active <= fw_in;
            pend_flag <= 1'b0;
        end else begin
            if (en && carry && pend_flag) begin
                fw_active <= fw_pending;
                pend_flag <= 1'b0;
            end
            if (fw_load) begin
                fw_pending <= fw_in;
                pend_flag  <= 1'b1;
            end
        end
    end

    // Stage 1: offset phase truncated to quadrant + table index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ph <= '0;
        else        ph <= PW'((acc + phase_off) >> (N - PW));
    end

    // Stage 2: quarter-wave lookup; cosine is the sine of the next quadrant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mag_s <= '0;
            mag_c <= '0;
            neg_s <= 1'b0;
            neg_c <= 1'b0;
        end else begin
            mag_s <= MW'(q[0] ? QTAB[~idx] : QTAB[idx]);
            mag_c <= MW'(q[0] ? QTAB[idx] : QTAB[~idx]);
            neg_s <= q[1];
            neg_c <= q[1] ^ q[0];
        end
    end

    // Stage 3: apply sign and register the samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sine   <= '0;
            cosine <= '0;
        end else begin
            sine   <= neg_s ? -{1'b0, mag_s} : {1'b0, mag_s};
            cosine <= neg_c ? -{1'b0, mag_c} : {1'b0, mag_c};
        end
    end

    // en delayed three clocks marks the samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vpipe     <= '0;
            out_valid <= 1'b0;
        end else begin
            vpipe     <= {vpipe[0], en};
            out_valid <= vpipe[1];
        end
    end

    // Heartbeat: toggle led whenever the wrap counter rolls over
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt <= '0;
            led  <= 1'b0;
        end else if (wrap) begin
            wcnt <= wcnt + 1'b1;
            if (&wcnt) led <= ~led;
        end
    end
endmodule

// File: tb/tb_ddfs_iq.sv
// tb_ddfs_iq: scoreboard plus table-driven bench for the quadrature DDFS
module tb_ddfs_iq;
    localparam int  N   = 16;
    localparam int  M   = 10;
    localparam int  AMP = 511;
    localparam int  SH  = 8;
    localparam real PI  = 3.14159265358979;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         en = 1'b1;
    logic [N-1:0] fw_in = '0;
    logic         fw_load = 1'b0;
    logic         hop_sync = 1'b0;
    logic [N-1:0] phase_off = '0;
    logic [M-1:0] sine;
    logic [M-1:0] cosine;
    logic         out_valid;
    logic         wrap;
    logic         led;

    ddfs_iq #(.N(N), .M(M), .LUT_AW(6), .BIT_COUNT(2)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .fw_in(fw_in), .fw_load(fw_load),
        .hop_sync(hop_sync), .phase_off(phase_off), .sine(sine), .cosine(cosine),
        .out_valid(out_valid), .wrap(wrap), .led(led)
    );

    always #5 clk = ~clk;

    typedef struct { int s; int c; bit v; } exp_t;
    typedef struct { logic [N-1:0] off; int s; int c; } vec_t;

    exp_t sb[$];
    int   chk = 0;
    int   err = 0;
    int   m_acc, m_fw, m_pend, m_wcnt;
    bit   m_pflag, m_wrap, m_led;

    function automatic int rnd(real x);
        return $rtoi(x < 0.0 ? x - 0.5 : x + 0.5);
    endfunction

    function automatic real ang(int ph);
        return 2.0 * PI * (real'(ph >> SH) + 0.5) / real'(1 << (N - SH));
    endfunction

    function automatic int ref_s(int ph);
        return rnd(AMP * $sin(ang(ph)));
    endfunction

    function automatic int ref_c(int ph);
        return rnd(AMP * $cos(ang(ph)));
    endfunction

    task automatic check(input string name, input int act, input int expv);
        chk++;
        if (act != expv) begin
            err++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        exp_t e;
        m_acc = 0; m_fw = 0; m_pend = 0; m_wcnt = 0;
        m_pflag = 0; m_wrap = 0; m_led = 0;
        sb.delete();
        e.s = 0; e.c = 0; e.v = 0;
        sb.push_back(e);
        e.s = ref_s(0); e.c = ref_c(0); e.v = 0;
        sb.push_back(e);
    endtask

    // one clock: predict, advance the model, clock the DUT, compare
    task automatic step();
        exp_t e;
        int   ph, sum;
        bit   carry, hop;
        ph = (m_acc + phase_off) & 'hFFFF;
        e.s = ref_s(ph); e.c = ref_c(ph); e.v = en;
        sb.push_back(e);
        sum   = m_acc + m_fw;
        carry = en && (sum > 'hFFFF);
        if (m_wrap) begin
            m_wcnt = (m_wcnt + 1) % 4;
            if (m_wcnt == 0) m_led = !m_led;
        end
        m_wrap = carry;
        if (en) m_acc = sum & 'hFFFF;
        hop = carry && m_pflag;
        if (fw_load && !hop_sync) begin
            m_fw = fw_in; m_pflag = 0;
        end else begin
            if (hop) begin m_fw = m_pend; m_pflag = 0; end
            if (fw_load) begin m_pend = fw_in; m_pflag = 1; end
        end
        @(posedge clk);
        #1;
        check("wrap", wrap, m_wrap);
        check("led", led, m_led);
        if (sb.size() > 2) begin
            e = sb.pop_front();
            check("sine", $signed(sine), e.s);
            check("cosine", $signed(cosine), e.c);
            check("out_valid", out_valid, e.v);
        end
    endtask

    task automatic count_until_wrap(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!wrap && n < 64);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_sine"}, sine, 0);
        check({tag, "_cosine"}, cosine, 0);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_wrap"}, wrap, 0);
        check({tag, "_led"}, led, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        vec_t tbl[8];
        int   n;
        bit   l0;
        tbl[0] = '{16'h0000,    6,  511};
        tbl[1] = '{16'h8000,   -6, -511};
        tbl[2] = '{16'h4000,  511,   -6};
        tbl[3] = '{16'hC000, -511,    6};
        tbl[4] = '{16'h1000,  201,  470};
        tbl[5] = '{16'h2000,  366,  357};
        tbl[6] = '{16'h6000,  357, -366};
        tbl[7] = '{16'hFF00,   -6,  511};

        #1 rst_n = 1'b0;
        #2 check_zero("reset");
        #9 rst_n = 1'b1;
        model_reset();

        // defaults: fw=0, offset 0 -> +6/+511, never wraps
        repeat (8) step();
        check("default_sine", $signed(sine), 6);
        check("default_cos", $signed(cosine), 511);
        check("default_valid", out_valid, 1);

        // static phase offsets
        for (int i = 0; i < 8; i++) begin
            phase_off = tbl[i].off;
            repeat (3) step();
            check("tbl_sine", $signed(sine), tbl[i].s);
            check("tbl_cos", $signed(cosine), tbl[i].c);
        end

        // offset reaches the outputs two edges after the edge that samples it
        phase_off = 16'h0000;
        repeat (3) step();
        phase_off = 16'h8000;
        step();
        step();
        check("lat_hold", $signed(sine), 6);
        step();
        check("lat_new", $signed(sine), -6);
        phase_off = 16'h0000;
        repeat (3) step();

        // immediate load of a quarter-cycle word
        hop_sync = 1'b0; fw_in = 16'h4000; fw_load = 1'b1;
        step();
        fw_load = 1'b0;
        count_until_wrap(n);
        count_until_wrap(n);
        check("wrap_period", n, 4);
        l0 = led; n = 0;
        while (led == l0 && n < 40) begin step(); n++; end
        l0 = led; n = 0;
        while (led == l0 && n < 40) begin step(); n++; end
        check("led_period", n, 16);

        // synchronous hop; second load lands on the carrying cycle
        for (int k = 0; k < 8 && m_acc != 'h4000; k++) step();
        hop_sync = 1'b1; fw_in = 16'h2000; fw_load = 1'b1;
        step();
        fw_load = 1'b0;
        for (int k = 0; k < 8 && m_acc != 'hC000; k++) step();
        fw_in = 16'h1000; fw_load = 1'b1;
        step();
        fw_load = 1'b0;
        check("hop_wrap", wrap, 1);
        count_until_wrap(n);
        check("hop_first", n, 8);
        count_until_wrap(n);
        check("hop_second", n, 16);

        // enable toggling 1,0,0,1
        en = 1'b1; step();
        en = 1'b0; step(); step();
        en = 1'b1; step();
        repeat (4) step();

        // asynchronous reset with a hop pending
        fw_in = 16'h3000; hop_sync = 1'b1; fw_load = 1'b1;
        step();
        fw_load = 1'b0; hop_sync = 1'b0;
        step(); step();
        #2 rst_n = 1'b0;
        #1 check_zero("async");
        @(posedge clk);
        #1 check_zero("held");
        rst_n = 1'b1;
        model_reset();
        n = 0;
        repeat (40) begin
            step();
            n += wrap;
        end
        check("post_reset_wraps", n, 0);
        check("post_reset_sine", $signed(sine), 6);
        check("post_reset_cos", $signed(cosine), 511);

        $display("CHECKS %0d ERRORS %0d", chk, err);
        $finish;
    end
endmodule
